// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite scan engine: object-word field positions,
// scan FSM state encoding and the size-code to row-height mapping.
package sprite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_W1,
        ST_RD_W0,
        ST_TEST,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Word 1 field positions (attribute word)
    localparam int W1_SIZE_X_LSB = 24;
    localparam int W1_SIZE_Y_LSB = 21;
    localparam int W1_HFLIP      = 20;
    localparam int W1_VFLIP      = 19;
    localparam int W1_Z_LSB      = 17;
    localparam int W1_ACTIVE     = 16;

    // Word 0 field positions (tile / placement word)
    localparam int W0_PAL_LSB    = 25;
    localparam int W0_TABLE      = 24;
    localparam int W0_TILE_X_LSB = 20;
    localparam int W0_TILE_Y_LSB = 16;

    // Object height in rows: 8 rows per size step, size code 0 is 8 rows.
    function automatic logic [6:0] sprite_height(input logic [2:0] size_code);
        return {1'b0, size_code, 3'b000} + 7'd8;
    endfunction

endpackage

// File: rtl/sprite_row_test.sv
// Combinational scanline intersection test for one object: row offset,
// object height, hit decision and the vertically flipped row index.
module sprite_row_test
    import sprite_pkg::*;
#(
    parameter int Y_W = 10
) (
    input  logic [Y_W-1:0] y_i,
    input  logic [Y_W-1:0] y_pos_i,
    input  logic [2:0]     size_y_i,
    input  logic           vflip_i,
    input  logic           active_i,
    output logic [Y_W-1:0] row_o,
    output logic [6:0]     height_o,
    output logic           hit_o,
    output logic [5:0]     spr_row_o
);

    // Row wraps modulo the coordinate space so objects straddling the top edge still hit.
    always_comb begin
        row_o     = y_i - y_pos_i;
        height_o  = sprite_height(size_y_i);
        hit_o     = active_i && (row_o < Y_W'(height_o));
        spr_row_o = vflip_i ? (height_o[5:0] - 6'd1 - row_o[5:0]) : row_o[5:0];
    end

endmodule

// File: rtl/sprite_scan_engine.sv
// Per-scanline sprite object walker: scans object RAM from a priority index
// with wrap-around, hands intersecting objects to the line buffer and keeps
// per-line hit/overflow/incomplete status.
module sprite_scan_engine
    import sprite_pkg::*;
#(
    parameter int IDX_W        = 8,
    parameter int MAX_PER_LINE = 32,
    parameter int Y_W          = 10,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scanline_start,
    input  logic [Y_W-1:0]   y,
    input  logic [IDX_W-1:0] sprite_priority,
    output logic [IDX_W:0]   ram_addr,
    input  logic [31:0]      ram_data,
    output logic             spr_valid,
    input  logic             spr_ready,
    output logic [Y_W-1:0]   spr_x,
    output logic [5:0]       spr_row,
    output logic [2:0]       spr_size_x,
    output logic [2:0]       spr_size_y,
    output logic             spr_hflip,
    output logic [1:0]       spr_z,
    output logic [4:0]       spr_palette,
    output logic             spr_tile_table,
    output logic [3:0]       spr_tile_x,
    output logic [3:0]       spr_tile_y,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow,
    output logic             incomplete,
    output logic             scan_done
);

    localparam logic [IDX_W:0]   VISIT_END = {1'b1, {IDX_W{1'b0}}};
    localparam logic [CNT_W-1:0] HIT_LIMIT = CNT_W'(MAX_PER_LINE);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     visited_q, visited_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic               overflow_q, overflow_d;
    logic               incomplete_q, incomplete_d;
    logic [31:0]        word1_q, word1_d;
    logic               spr_valid_q, spr_valid_d;
    logic [Y_W-1:0]     spr_x_q, spr_x_d;
    logic [5:0]         spr_row_q, spr_row_d;
    logic [2:0]         spr_size_x_q, spr_size_x_d;
    logic [2:0]         spr_size_y_q, spr_size_y_d;
    logic               spr_hflip_q, spr_hflip_d;
    logic [1:0]         spr_z_q, spr_z_d;
    logic [4:0]         spr_palette_q, spr_palette_d;
    logic               spr_tile_table_q, spr_tile_table_d;
    logic [3:0]         spr_tile_x_q, spr_tile_x_d;
    logic [3:0]         spr_tile_y_q, spr_tile_y_d;
    logic               advance;

    logic [Y_W-1:0]     row_w;
    logic [6:0]         height_w;
    logic               hit_w;
    logic [5:0]         row_map_w;
    logic               unused_bits;

    sprite_row_test #(.Y_W(Y_W)) u_row_test (
        .y_i       (y),
        .y_pos_i   (word1_q[Y_W-1:0]),
        .size_y_i  (word1_q[W1_SIZE_Y_LSB +: 3]),
        .vflip_i   (word1_q[W1_VFLIP]),
        .active_i  (word1_q[W1_ACTIVE]),
        .row_o     (row_w),
        .height_o  (height_w),
        .hit_o     (hit_w),
        .spr_row_o (row_map_w)
    );

    assign unused_bits = ^{word1_q[31:27], word1_q[15:Y_W], ram_data[31:30],
                           ram_data[15:Y_W], row_w, height_w};

    // The address only toggles between the two words of the current index, so it is stable while stalled in EMIT.
    assign ram_addr       = {idx_q, state_q == ST_RD_W1};
    assign spr_valid      = spr_valid_q;
    assign spr_x          = spr_x_q;
    assign spr_row        = spr_row_q;
    assign spr_size_x     = spr_size_x_q;
    assign spr_size_y     = spr_size_y_q;
    assign spr_hflip      = spr_hflip_q;
    assign spr_z          = spr_z_q;
    assign spr_palette    = spr_palette_q;
    assign spr_tile_table = spr_tile_table_q;
    assign spr_tile_x     = spr_tile_x_q;
    assign spr_tile_y     = spr_tile_y_q;
    assign hit_count      = hit_count_q;
    assign overflow       = overflow_q;
    assign incomplete     = incomplete_q;
    assign scan_done      = (state_q == ST_DONE);

    // Scan sequencing: read both words, test, emit, then advance; a new scanline start overrides everything.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        visited_d        = visited_q;
        hit_count_d      = hit_count_q;
        overflow_d       = overflow_q;
        incomplete_d     = incomplete_q;
        word1_d          = word1_q;
        spr_valid_d      = spr_valid_q;
        spr_x_d          = spr_x_q;
        spr_row_d        = spr_row_q;
        spr_size_x_d     = spr_size_x_q;
        spr_size_y_d     = spr_size_y_q;
        spr_hflip_d      = spr_hflip_q;
        spr_z_d          = spr_z_q;
        spr_palette_d    = spr_palette_q;
        spr_tile_table_d = spr_tile_table_q;
        spr_tile_x_d     = spr_tile_x_q;
        spr_tile_y_d     = spr_tile_y_q;
        advance          = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_RD_W1: state_d = ST_RD_W0;
            ST_RD_W0: begin
                word1_d = ram_data;
                state_d = ST_TEST;
            end
            ST_TEST: begin
                if (hit_w) begin
                    spr_x_d          = ram_data[Y_W-1:0];
                    spr_row_d        = row_map_w;
                    spr_size_x_d     = word1_q[W1_SIZE_X_LSB +: 3];
                    spr_size_y_d     = word1_q[W1_SIZE_Y_LSB +: 3];
                    spr_hflip_d      = word1_q[W1_HFLIP];
                    spr_z_d          = word1_q[W1_Z_LSB +: 2];
                    spr_palette_d    = ram_data[W0_PAL_LSB +: 5];
                    spr_tile_table_d = ram_data[W0_TABLE];
                    spr_tile_x_d     = ram_data[W0_TILE_X_LSB +: 4];
                    spr_tile_y_d     = ram_data[W0_TILE_Y_LSB +: 4];
                    spr_valid_d      = 1'b1;
                    state_d          = ST_EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (spr_ready) begin
                    hit_count_d = hit_count_q + 1'b1;
                    spr_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            idx_d     = idx_q + 1'b1;
            visited_d = visited_q + 1'b1;
            if (visited_d == VISIT_END) begin
                state_d = ST_DONE;
            end else if (hit_count_d == HIT_LIMIT) begin
                overflow_d = 1'b1;
                state_d    = ST_DONE;
            end else begin
                state_d = ST_RD_W1;
            end
        end

        if (scanline_start) begin
            incomplete_d = (state_q != ST_IDLE) && (state_q != ST_DONE);
            idx_d        = sprite_priority;
            visited_d    = '0;
            hit_count_d  = '0;
            overflow_d   = 1'b0;
            spr_valid_d  = 1'b0;
            state_d      = ST_RD_W1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            visited_q        <= '0;
            hit_count_q      <= '0;
            overflow_q       <= 1'b0;
            incomplete_q     <= 1'b0;
            word1_q          <= '0;
            spr_valid_q      <= 1'b0;
            spr_x_q          <= '0;
            spr_row_q        <= '0;
            spr_size_x_q     <= '0;
            spr_size_y_q     <= '0;
            spr_hflip_q      <= 1'b0;
            spr_z_q          <= '0;
            spr_palette_q    <= '0;
            spr_tile_table_q <= 1'b0;
            spr_tile_x_q     <= '0;
            spr_tile_y_q     <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            visited_q        <= visited_d;
            hit_count_q      <= hit_count_d;
            overflow_q       <= overflow_d;
            incomplete_q     <= incomplete_d;
            word1_q          <= word1_d;
            spr_valid_q      <= spr_valid_d;
            spr_x_q          <= spr_x_d;
            spr_row_q        <= spr_row_d;
            spr_size_x_q     <= spr_size_x_d;
            spr_size_y_q     <= spr_size_y_d;
            spr_hflip_q      <= spr_hflip_d;
            spr_z_q          <= spr_z_d;
            spr_palette_q    <= spr_palette_d;
            spr_tile_table_q <= spr_tile_table_d;
            spr_tile_x_q     <= spr_tile_x_d;
            spr_tile_y_q     <= spr_tile_y_d;
        end
    end

endmodule

// File: tb/tb_sprite_scan_engine.sv
// Testbench for sprite_scan_engine with a 4-hit line limit and a registered
// object RAM model; emitted descriptors are checked against a scoreboard queue.
module tb_sprite_scan_engine;

    localparam int IDX_W        = 8;
    localparam int MAX_PER_LINE = 4;
    localparam int Y_W          = 10;
    localparam int CNT_W        = 6;

    typedef struct packed {
        logic [9:0] x;
        logic [5:0] row;
        logic [2:0] size_x;
        logic [2:0] size_y;
        logic       hflip;
        logic [1:0] z;
        logic [4:0] pal;
        logic       tbl;
        logic [3:0] tile_x;
        logic [3:0] tile_y;
    } desc_t;

    typedef struct {
        logic [15:0] yPos;
        logic [2:0]  sizeY;
        logic        vflip;
        logic        active;
        logic [9:0]  y;
        logic        expHit;
        logic [5:0]  expRow;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             scanline_start;
    logic [Y_W-1:0]   y;
    logic [IDX_W-1:0] sprite_priority;
    logic [IDX_W:0]   ram_addr;
    logic [31:0]      ram_data = '0;
    logic             spr_valid;
    logic             spr_ready;
    logic [Y_W-1:0]   spr_x;
    logic [5:0]       spr_row;
    logic [2:0]       spr_size_x;
    logic [2:0]       spr_size_y;
    logic             spr_hflip;
    logic [1:0]       spr_z;
    logic [4:0]       spr_palette;
    logic             spr_tile_table;
    logic [3:0]       spr_tile_x;
    logic [3:0]       spr_tile_y;
    logic [CNT_W-1:0] hit_count;
    logic             overflow;
    logic             incomplete;
    logic             scan_done;

    logic [31:0] mem [0:511];
    desc_t       dutDesc;
    desc_t       sb[$];
    desc_t       stallExp;
    vec_t        vec[10];
    logic        readyRandom = 1'b0;
    int          checkCount  = 0;
    int          passCount   = 0;
    int          cyc;
    int          cnt;

    sprite_scan_engine #(
        .IDX_W(IDX_W), .MAX_PER_LINE(MAX_PER_LINE), .Y_W(Y_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .scanline_start(scanline_start), .y(y),
        .sprite_priority(sprite_priority), .ram_addr(ram_addr), .ram_data(ram_data),
        .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_x(spr_x), .spr_row(spr_row),
        .spr_size_x(spr_size_x), .spr_size_y(spr_size_y), .spr_hflip(spr_hflip),
        .spr_z(spr_z), .spr_palette(spr_palette), .spr_tile_table(spr_tile_table),
        .spr_tile_x(spr_tile_x), .spr_tile_y(spr_tile_y), .hit_count(hit_count),
        .overflow(overflow), .incomplete(incomplete), .scan_done(scan_done)
    );

    assign dutDesc = {spr_x, spr_row, spr_size_x, spr_size_y, spr_hflip, spr_z,
                      spr_palette, spr_tile_table, spr_tile_x, spr_tile_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Object RAM with one cycle read latency
    always @(posedge clk) ram_data <= mem[ram_addr];

    // Random line-buffer backpressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (readyRandom) spr_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard consumer: every accepted descriptor must match the oldest expectation
    always @(negedge clk) begin
        if (rst && spr_valid && spr_ready) begin
            if (sb.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_emit: got descriptor 0x%0h, expected none", dutDesc);
            end else begin
                checkOutput("emit_desc", dutDesc, sb.pop_front());
            end
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    endtask

    task automatic putSprite(input int idx, input logic [15:0] yPos, input logic [2:0] sy,
                             input logic vf, input logic act);
        logic [7:0]  i;
        logic [15:0] xPos;
        i    = 8'(idx);
        xPos = 16'hA000 | 16'(idx * 3);
        mem[2 * idx]     = {2'b11, i[4:0], i[5], i[3:0], i[7:4], xPos};
        mem[2 * idx + 1] = {5'b0, i[2:0], sy, i[0], vf, i[2:1], act, yPos};
    endtask

    function automatic desc_t expDesc(input int idx, input logic [2:0] sy, input logic [5:0] row);
        logic [7:0] i;
        desc_t      d;
        i        = 8'(idx);
        d.x      = 10'(idx * 3);
        d.row    = row;
        d.size_x = i[2:0];
        d.size_y = sy;
        d.hflip  = i[0];
        d.z      = i[2:1];
        d.pal    = i[4:0];
        d.tbl    = i[5];
        d.tile_x = i[3:0];
        d.tile_y = i[7:4];
        return d;
    endfunction

    task automatic applyStimulus(input logic [IDX_W-1:0] prio, input logic [Y_W-1:0] yv);
        @(negedge clk);
        sprite_priority = prio;
        y               = yv;
        scanline_start  = 1'b1;
        @(posedge clk);
        #1;
        scanline_start  = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!scan_done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!scan_done) begin
            checkCount++;
            $display("[TB] FAIL %s_timeout: got scan_done 0 after %0d cycles, expected 1", name, cycles);
        end
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!spr_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_valid"}, spr_valid, 1);
    endtask

    task automatic checkStatus(input string name, input int hits, input logic ovf, input logic inc);
        checkOutput({name, "_hits"}, hit_count, hits);
        checkOutput({name, "_overflow"}, overflow, ovf);
        checkOutput({name, "_incomplete"}, incomplete, inc);
        checkOutput({name, "_done"}, scan_done, 1);
        checkOutput({name, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec[0] = '{16'd10,    3'd1, 1'b1, 1'b1, 10'd12,  1'b1, 6'd13};
        vec[1] = '{16'd10,    3'd1, 1'b1, 1'b1, 10'd26,  1'b0, 6'd0};
        vec[2] = '{16'd10,    3'd1, 1'b1, 1'b1, 10'd25,  1'b1, 6'd0};
        vec[3] = '{16'd100,   3'd0, 1'b0, 1'b1, 10'd103, 1'b1, 6'd3};
        vec[4] = '{16'd10,    3'd0, 1'b0, 1'b1, 10'd9,   1'b0, 6'd0};
        vec[5] = '{16'h07FC,  3'd0, 1'b0, 1'b1, 10'd3,   1'b1, 6'd7};
        vec[6] = '{16'd10,    3'd1, 1'b1, 1'b0, 10'd12,  1'b0, 6'd0};
        vec[7] = '{16'd0,     3'd7, 1'b1, 1'b1, 10'd63,  1'b1, 6'd0};
        vec[8] = '{16'd0,     3'd7, 1'b0, 1'b1, 10'd64,  1'b0, 6'd0};
        vec[9] = '{16'd0,     3'd7, 1'b0, 1'b1, 10'd63,  1'b1, 6'd63};

        rst = 1'b0;
        scanline_start = 1'b0;
        y = '0;
        sprite_priority = '0;
        spr_ready = 1'b0;
        clearMem();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", spr_valid, 0);
        checkOutput("reset_hits", hit_count, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_incomplete", incomplete, 0);
        checkOutput("reset_done", scan_done, 0);
        checkOutput("reset_addr", ram_addr, 0);
        checkOutput("reset_desc", dutDesc, 0);
        rst = 1'b1;

        // Single-object intersection vectors
        spr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clearMem();
            putSprite(5, vec[i].yPos, vec[i].sizeY, vec[i].vflip, vec[i].active);
            if (vec[i].expHit) sb.push_back(expDesc(5, vec[i].sizeY, vec[i].expRow));
            applyStimulus(8'd0, vec[i].y);
            waitDone($sformatf("vec%0d", i), 2000, cyc);
            checkOutput($sformatf("vec%0d_hits", i), hit_count, {63'b0, vec[i].expHit});
            checkOutput($sformatf("vec%0d_sb_left", i), sb.size(), 0);
        end

        // Priority start with wrap-around, full-speed scan timing
        clearMem();
        putSprite(252, 16'd100, 3'd0, 1'b0, 1'b1);
        putSprite(3,   16'd100, 3'd0, 1'b0, 1'b1);
        putSprite(254, 16'd200, 3'd0, 1'b0, 1'b1);
        sb.push_back(expDesc(252, 3'd0, 6'd3));
        sb.push_back(expDesc(3, 3'd0, 6'd3));
        applyStimulus(8'd250, 10'd103);
        waitDone("wrap", 2000, cyc);
        checkOutput("wrap_cycles", cyc, 770);
        checkStatus("wrap", 2, 1'b0, 1'b0);

        // Six intersecting objects with random backpressure: limit reached early
        clearMem();
        for (int k = 1; k <= 6; k++) putSprite(10 * k, 16'd50, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) sb.push_back(expDesc(10 * k, 3'd0, 6'd0));
        readyRandom = 1'b1;
        applyStimulus(8'd0, 10'd50);
        waitDone("ovf", 4000, cyc);
        readyRandom = 1'b0;
        spr_ready = 1'b1;
        checkStatus("ovf", 4, 1'b1, 1'b0);

        // Exactly the limit, last hit on the final visited index
        clearMem();
        putSprite(150, 16'd50, 3'd0, 1'b0, 1'b1);
        putSprite(200, 16'd50, 3'd0, 1'b0, 1'b1);
        putSprite(20,  16'd50, 3'd0, 1'b0, 1'b1);
        putSprite(99,  16'd50, 3'd0, 1'b0, 1'b1);
        sb.push_back(expDesc(150, 3'd0, 6'd0));
        sb.push_back(expDesc(200, 3'd0, 6'd0));
        sb.push_back(expDesc(20, 3'd0, 6'd0));
        sb.push_back(expDesc(99, 3'd0, 6'd0));
        applyStimulus(8'd100, 10'd50);
        waitDone("exact", 2000, cyc);
        checkOutput("exact_cycles", cyc, 772);
        checkStatus("exact", 4, 1'b0, 1'b0);

        // Line buffer stall: descriptor and RAM address hold for 20 cycles
        clearMem();
        spr_ready = 1'b0;
        putSprite(7, 16'd50, 3'd0, 1'b0, 1'b1);
        stallExp = expDesc(7, 3'd0, 6'd0);
        sb.push_back(stallExp);
        applyStimulus(8'd0, 10'd50);
        waitValid("stall");
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall_hold%0d", k), {spr_valid, ram_addr, dutDesc},
                        {1'b1, 9'd14, stallExp});
        end
        spr_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("accept_valid", spr_valid, 0);
        checkOutput("accept_hits", hit_count, 1);
        waitDone("stall", 2000, cyc);
        checkStatus("stall", 1, 1'b0, 1'b0);

        // Restart while reading word 0 of index 1
        clearMem();
        putSprite(0, 16'd50, 3'd0, 1'b0, 1'b1);
        putSprite(1, 16'd50, 3'd0, 1'b0, 1'b1);
        sb.push_back(expDesc(0, 3'd0, 6'd0));
        applyStimulus(8'd0, 10'd50);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pre_restart_addr", ram_addr, 2);
        checkOutput("pre_restart_hits", hit_count, 1);
        sb.push_back(expDesc(0, 3'd0, 6'd0));
        sb.push_back(expDesc(1, 3'd0, 6'd0));
        applyStimulus(8'd200, 10'd50);
        checkOutput("restart_incomplete", incomplete, 1);
        checkOutput("restart_hits", hit_count, 0);
        checkOutput("restart_addr", ram_addr, 401);
        waitDone("restart", 2000, cyc);
        checkStatus("restart", 2, 1'b0, 1'b1);

        // Reset while a descriptor is waiting in EMIT
        clearMem();
        putSprite(3, 16'd50, 3'd0, 1'b0, 1'b1);
        putSprite(5, 16'd50, 3'd0, 1'b0, 1'b1);
        sb.push_back(expDesc(3, 3'd0, 6'd0));
        applyStimulus(8'd0, 10'd50);
        cnt = 0;
        while (hit_count != 1 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        spr_ready = 1'b0;
        checkOutput("rst_pre_hits", hit_count, 1);
        waitValid("rst_pre");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        checkOutput("rst_valid", spr_valid, 0);
        checkOutput("rst_hits", hit_count, 0);
        checkOutput("rst_done", scan_done, 0);
        checkOutput("rst_addr", ram_addr, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_idle_hold", {spr_valid, scan_done, ram_addr}, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sprite_scan_engine.md
Name: sprite_scan_engine

Overview:
Parametrised successor to the per-scanline sprite object walker. It scans sprite object RAM once per scanline, starting at a programmable priority index with wrap-around, and tests each active object for intersection with the next scanline. Hits go to the line buffer over a valid/ready handshake. The block enforces a configurable per-line sprite limit and reports overflow, incomplete-scan and hit-count status to the processor-visible register file. It sits between sprite object VRAM (port B) and the line buffer.

Parameters:
IDX_W, 8, sprite index width; SPRITE_COUNT = 2**IDX_W
MAX_PER_LINE, 32, maximum hits emitted per scanline (1..SPRITE_COUNT)
Y_W, 10, scanline coordinate width
CNT_W, 6, hit counter width; must hold MAX_PER_LINE

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
scanline_start  in  1  one-cycle pulse: begin a new scan
y  in  Y_W  scanline being prepared
sprite_priority  in  IDX_W  first index scanned
ram_addr  out  IDX_W+1  object RAM word address {idx, word}
ram_data  in  32  object RAM read data, 1-cycle latency
spr_valid  out  1  hit descriptor valid
spr_ready  in  1  line buffer accepts descriptor
spr_x  out  Y_W  object X (word0[Y_W-1:0])
spr_row  out  6  row within object after vFlip
spr_size_x, spr_size_y  out  3 each  size codes
spr_hflip  out  1  horizontal flip
spr_z  out  2  priority layer
spr_palette  out  5  palette
spr_tile_table  out  1  tile table select
spr_tile_x, spr_tile_y  out  4 each  base tile
hit_count  out  CNT_W  hits emitted this line
overflow  out  1  limit reached before scan finished
incomplete  out  1  previous scan aborted by scanline_start
scan_done  out  1  level, scan finished for this line

Behaviour:
- One clock; reset is synchronous and active-low (rst low at posedge clk). On reset: state IDLE, all outputs 0, ram_addr 0.
- Word layout: word1 = {5'b0, size_x[26:24], size_y[23:21], hflip[20], vflip[19], z[18:17], active[16], y_pos[15:0]}; word0 = {2'b0, palette[29:25], table[24], tile_x[23:20], tile_y[19:16], x_pos[15:0]}.
- States: IDLE, RD_W1, RD_W0, TEST, EMIT, DONE.
- scanline_start, in any state: idx <= sprite_priority, visited <= 0, hit_count <= 0, overflow <= 0, scan_done <= 0, spr_valid <= 0, go to RD_W1. incomplete <= 1 if prior state was not IDLE or DONE, else 0. Start wins over every other event in that cycle.
- RD_W1: ram_addr = {idx,1}; next RD_W0.
- RD_W0: capture word1; ram_addr = {idx,0}; next TEST.
- TEST: capture word0; row = (y - y_pos[Y_W-1:0]) mod 2**Y_W; height = 8*(size_y+1); hit = active && row < height. If hit: load spr_* with spr_row = vflip ? height-1-row : row, assert spr_valid, go EMIT. Otherwise advance.
- EMIT: hold spr_valid and all spr_* stable until spr_ready. On the accepting cycle: hit_count++, deassert spr_valid, advance.
- Advance: visited++, idx++ (wraps mod SPRITE_COUNT). If visited reaches SPRITE_COUNT, go DONE. Else if hit_count == MAX_PER_LINE, set overflow and go DONE. Else go RD_W1.
- DONE: scan_done = 1; wait for scanline_start.
- Throughput: miss = 3 cycles/sprite; hit = 4 cycles plus ready stall.
- Overflow is set only when a sprite remains unvisited at the limit. Exactly MAX_PER_LINE hits on the final sprite gives no overflow.
- Status outputs hold until the next scanline_start.

Decomposition:
- Package sprite_pkg: word-field bit positions, state encodings, and a height function (size code to rows).
- One sub-module, sprite_row_test: combinational row, height, hit and vFlip mapping. It is reused by the background-priority logic.

Test Plan:
- Reset mid-EMIT with spr_valid=1 -> next cycle spr_valid=0, state IDLE, hit_count=0.
- priority=250, sprites 252 and 3 active at y_pos=100, size_y=0, y=103 -> two emits in order 252 then 3, spr_row=3, hit_count=2, scan_done=1 after 256 visits.
- vflip=1, size_y=1 (16 rows), y_pos=10, y=12 -> spr_row=13. y=26 -> no hit (boundary).
- MAX_PER_LINE=4, 6 intersecting sprites -> 4 emits, overflow=1. With exactly 4 hits, the last at index priority-1 -> overflow=0.
- spr_ready held low 20 cycles -> spr_* stable and no RAM address change; accepted on the first ready cycle.
- scanline_start during RD_W0 -> incomplete=1, scan restarts at the new sprite_priority, counters cleared.
